// File: rtl/wbu_pkg.sv
// Shared constants and FSM state type for the wbu return-path stages.
package wbu_pkg;

    localparam int WBU_CWW = 36;

    localparam logic [5:0] HDR_IDLE     = 6'h0;
    localparam logic [5:0] HDR_IDLEBUSY = 6'h1;
    localparam logic [5:0] HDR_INT      = 6'h4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/wbuintlatch.sv
// Per-channel rising-edge latch: a rise sets its pending bit, which stays set
// until the interrupt word that reported it is accepted downstream.
module wbuintlatch #(
    parameter int NINT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NINT-1:0] i_int,
    input  logic [NINT-1:0] clr,
    output logic [NINT-1:0] pending
);

    logic [NINT-1:0] prev;
    logic [NINT-1:0] rise;

    assign rise = i_int & ~prev;

    // A rise on the clearing cycle wins over the clear, so no edge is lost.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev    <= '0;
            pending <= '0;
        end else begin
            prev    <= i_int;
            pending <= (pending & ~clr) | rise;
        end
    end

endmodule

// File: rtl/wbuidleintn.sv
// Idle/interrupt inserter for the wbu return path with NINT interrupt channels.
// Define WBUIDLEINT_RESEND_EN to re-announce held-high lines once per idle period.
module wbuidleintn
    import wbu_pkg::*;
#(
    parameter int NINT   = 4,
    parameter int LGIDLE = 26
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stb,
    input  logic [WBU_CWW-1:0] i_codword,
    input  logic               i_cyc,
    input  logic [NINT-1:0]    i_int,
    output logic               o_stb,
    output logic [WBU_CWW-1:0] o_codword,
    output logic               o_busy,
    input  logic               i_tx_busy
);

    state_t state, next_state;

    logic [LGIDLE:0]    idle_cnt;
    logic               idle_expired;
    logic [NINT-1:0]    pending;
    logic [NINT-1:0]    clr;
    logic [NINT-1:0]    sent_mask;
    logic [NINT-1:0]    load_mask;
    logic               sent_is_int;
    logic               load_is_int;
    logic               load_en;
    logic               accept;
    logic [WBU_CWW-1:0] load_word;
    logic [29:0]        pend_payload;
`ifdef WBUIDLEINT_RESEND_EN
    logic [29:0]        int_payload;
`endif

    assign idle_expired = idle_cnt[LGIDLE];
    assign accept       = (state == SEND) && !i_tx_busy;
    // Only the bits actually reported in the accepted word are retired.
    assign clr          = (accept && sent_is_int) ? sent_mask : '0;

    wbuintlatch #(
        .NINT(NINT)
    ) u_latch (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_int   (i_int),
        .clr     (clr),
        .pending (pending)
    );

    always_comb begin
        pend_payload             = '0;
        pend_payload[NINT-1:0]   = pending;
`ifdef WBUIDLEINT_RESEND_EN
        int_payload              = '0;
        int_payload[NINT-1:0]    = i_int;
`endif
    end

    always_comb begin
        load_en     = 1'b0;
        load_word   = '0;
        load_is_int = 1'b0;
        load_mask   = '0;
        if (i_stb) begin
            load_en   = 1'b1;
            load_word = i_codword;
        end else if (|pending) begin
            load_en     = 1'b1;
            load_word   = {HDR_INT, pend_payload};
            load_is_int = 1'b1;
            load_mask   = pending;
        end else if (idle_expired) begin
            load_en = 1'b1;
`ifdef WBUIDLEINT_RESEND_EN
            // Resent levels leave pending untouched, so load_is_int stays 0.
            if (|(i_int & ~pending))
                load_word = {HDR_INT, int_payload};
            else
                load_word = {(i_cyc ? HDR_IDLEBUSY : HDR_IDLE), 30'h0};
`else
            load_word = {(i_cyc ? HDR_IDLEBUSY : HDR_IDLE), 30'h0};
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_en) next_state = SEND;
            SEND:    if (!i_tx_busy) next_state = GAP;
            GAP:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_stb  = 1'b0;
        o_busy = 1'b0;
        case (state)
            IDLE:    begin o_stb = 1'b0; o_busy = 1'b0; end
            SEND:    begin o_stb = 1'b1; o_busy = 1'b1; end
            GAP:     begin o_stb = 1'b0; o_busy = 1'b1; end
            default: begin o_stb = 1'b0; o_busy = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_codword   <= '0;
            sent_is_int <= 1'b0;
            sent_mask   <= '0;
        end else if (state == IDLE && load_en) begin
            o_codword   <= load_word;
            sent_is_int <= load_is_int;
            sent_mask   <= load_mask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            idle_cnt <= '0;
        else if (i_stb || o_stb)
            idle_cnt <= '0;
        else if (!idle_cnt[LGIDLE])
            idle_cnt <= idle_cnt + (LGIDLE+1)'(1);
    end

endmodule

// File: tb/tb_wbuidleintn.sv
// Scoreboard bench for wbuidleintn (NINT=4, LGIDLE=4); honours WBUIDLEINT_RESEND_EN.
module tb_wbuidleintn;
    import wbu_pkg::*;

    localparam int NINT   = 4;
    localparam int LGIDLE = 4;

    localparam logic [35:0] W_IDLE  = 36'h0_0000_0000;
    localparam logic [35:0] W_IDLEB = 36'h0_4000_0000;
    localparam logic [35:0] W_INT1  = 36'h1_0000_0001;
    localparam logic [35:0] W_INT2  = 36'h1_0000_0002;
    localparam logic [35:0] W_INT4  = 36'h1_0000_0004;
    localparam logic [35:0] W_INT8  = 36'h1_0000_0008;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic            i_stb;
    logic [35:0]     i_codword;
    logic            i_cyc;
    logic [NINT-1:0] i_int;
    logic            o_stb;
    logic [35:0]     o_codword;
    logic            o_busy;
    logic            i_tx_busy;

    typedef struct {
        logic [35:0] word;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   cyc    = 0;
    int   t0     = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    wbuidleintn #(
        .NINT   (NINT),
        .LGIDLE (LGIDLE)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_stb     (i_stb),
        .i_codword (i_codword),
        .i_cyc     (i_cyc),
        .i_int     (i_int),
        .o_stb     (o_stb),
        .o_codword (o_codword),
        .o_busy    (o_busy),
        .i_tx_busy (i_tx_busy)
    );

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic stb, input logic [35:0] word);
        i_stb     = stb;
        i_codword = word;
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic expectWord(input logic [35:0] word, input int at);
        exp_t e;
        e.word = word;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic doReset();
        i_reset   = 1'b1;
        i_tx_busy = 1'b0;
        i_cyc     = 1'b0;
        i_int     = '0;
        applyStimulus(1'b0, 36'h0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        t0      = cyc;
        checkOutput("reset_stb",  36'(o_stb),  36'h0);
        checkOutput("reset_busy", 36'(o_busy), 36'h0);
        checkOutput("reset_word", o_codword,   36'h0);
    endtask

    // Monitor: every accepted word must match the queue head in value and cycle.
    always @(negedge i_clk) begin
        if (!i_reset && o_stb) begin
            if (!i_tx_busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got %h, expected none (cycle %0d)", o_codword, cyc);
                end else begin
                    head = sb.pop_front();
                    checkOutput("word",       o_codword, head.word);
                    checkOutput("word_cycle", 36'(cyc),  36'(head.at));
                end
            end else if (sb.size() != 0) begin
                checkOutput("stall_hold", o_codword, sb[0].word);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Data pass-through followed by two idle words (plain, then bus-busy header)
        doReset();
        waitUntil(t0 + 3);
        applyStimulus(1'b1, 36'h8_1234_5678);
        expectWord(36'h8_1234_5678, t0 + 4);
        expectWord(W_IDLE,  t0 + 22);
        expectWord(W_IDLEB, t0 + 40);
        waitUntil(t0 + 4);
        applyStimulus(1'b0, 36'h0);
        checkOutput("pass_busy_send", 36'(o_busy), 36'h1);
        waitUntil(t0 + 5);
        checkOutput("pass_stb_gap",  36'(o_stb),  36'h0);
        checkOutput("pass_busy_gap", 36'(o_busy), 36'h1);
        waitUntil(t0 + 6);
        checkOutput("pass_busy_idle", 36'(o_busy), 36'h0);
        waitUntil(t0 + 25);
        i_cyc = 1'b1;
        waitUntil(t0 + 43);
        checkOutput("pass_drained", 36'(sb.size()), 36'h0);

        // Stall with a protocol-violating strobe that must be dropped
        doReset();
        waitUntil(t0 + 3);
        applyStimulus(1'b1, 36'h9_ABCD_EF01);
        expectWord(36'h9_ABCD_EF01, t0 + 9);
        waitUntil(t0 + 4);
        applyStimulus(1'b0, 36'h0);
        i_tx_busy = 1'b1;
        waitUntil(t0 + 5);
        applyStimulus(1'b1, 36'hF_FFFF_FFFF);
        waitUntil(t0 + 6);
        applyStimulus(1'b0, 36'h0);
        waitUntil(t0 + 9);
        i_tx_busy = 1'b0;
        checkOutput("stall_stb_held", 36'(o_stb), 36'h1);
        waitUntil(t0 + 10);
        checkOutput("stall_gap_stb",  36'(o_stb),  36'h0);
        checkOutput("stall_gap_busy", 36'(o_busy), 36'h1);
        waitUntil(t0 + 11);
        checkOutput("stall_idle_busy", 36'(o_busy), 36'h0);
        waitUntil(t0 + 14);
        checkOutput("stall_drained", 36'(sb.size()), 36'h0);

        // Interrupt coalescing: later rise stays pending for a second word
        doReset();
        i_tx_busy = 1'b1;
        waitUntil(t0 + 2);
        i_int = 4'b0001;
        waitUntil(t0 + 3);
        i_int = 4'b0101;
        expectWord(W_INT1, t0 + 7);
        expectWord(W_INT4, t0 + 10);
        waitUntil(t0 + 7);
        i_tx_busy = 1'b0;
        waitUntil(t0 + 13);
        checkOutput("coalesce_drained", 36'(sb.size()), 36'h0);

        // Rise on the acceptance cycle survives the clear
        doReset();
        i_tx_busy = 1'b1;
        waitUntil(t0 + 2);
        i_int = 4'b0001;
        expectWord(W_INT1, t0 + 6);
        expectWord(W_INT2, t0 + 9);
        waitUntil(t0 + 6);
        i_tx_busy = 1'b0;
        i_int     = 4'b0011;
        waitUntil(t0 + 12);
        checkOutput("accept_rise_drained", 36'(sb.size()), 36'h0);

        // Priority: data first, interrupt three cycles later
        doReset();
        waitUntil(t0 + 3);
        applyStimulus(1'b1, 36'h7_0000_00AA);
        i_int = 4'b1000;
        expectWord(36'h7_0000_00AA, t0 + 4);
        expectWord(W_INT8, t0 + 7);
        waitUntil(t0 + 4);
        applyStimulus(1'b0, 36'h0);
        waitUntil(t0 + 10);
        checkOutput("priority_drained", 36'(sb.size()), 36'h0);

        // Reset mid-SEND, held line re-reported; then idle-period behaviour
        doReset();
        i_tx_busy = 1'b1;
        waitUntil(t0 + 2);
        i_int = 4'b0010;
        expectWord(W_INT2, t0 + 8);
        waitUntil(t0 + 4);
        checkOutput("rst_send_stb", 36'(o_stb), 36'h1);
        waitUntil(t0 + 5);
        i_reset = 1'b1;
        waitUntil(t0 + 6);
        i_reset   = 1'b0;
        i_tx_busy = 1'b0;
        checkOutput("rst_drop_stb",  36'(o_stb),  36'h0);
        checkOutput("rst_drop_busy", 36'(o_busy), 36'h0);
        waitUntil(t0 + 9);
        checkOutput("rst_rereport_drained", 36'(sb.size()), 36'h0);
`ifdef WBUIDLEINT_RESEND_EN
        expectWord(W_INT2, t0 + 26);
        expectWord(W_INT2, t0 + 44);
`else
        expectWord(W_IDLE, t0 + 26);
        expectWord(W_IDLE, t0 + 44);
`endif
        waitUntil(t0 + 47);
        checkOutput("resend_drained", 36'(sb.size()), 36'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
